// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state type and message helpers.
package midi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NOTE_W = 7;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [NOTE_W-1:0] CC_ALL_NOTES_OFF = 7'd123;
  localparam logic [NOTE_W-1:0] CC_ALL_SOUND_OFF = 7'd120;

  typedef enum logic [1:0] {
    P_IDLE,
    P_DATA1,
    P_DATA2,
    P_SYSEX
  } parser_state_e;

  // Program change and channel pressure carry a single data byte.
  function automatic logic is_one_data(input logic [BYTE_W-1:0] status);
    return (status[7:4] == PROG) || (status[7:4] == CHPRESS);
  endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser: running status, realtime pass-over, SysEx skip.
// The completed message is presented combinationally in the cycle of the
// byte that completes it, so a consumer can register its result one cycle later.
module midi_byte_parser
  import midi_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              midi_valid_i,
  input  logic [BYTE_W-1:0] midi_data_i,
  output logic              msg_valid_c,
  output logic [BYTE_W-1:0] msg_status_c,
  output logic [NOTE_W-1:0] msg_d1_c,
  output logic [NOTE_W-1:0] msg_d2_c
);

  parser_state_e     state_q, state_d;
  logic [BYTE_W-1:0] rs_q, rs_d;    // running status, 0 when none (bit 7 = valid)
  logic [NOTE_W-1:0] d1_q, d1_d;

  // Next-state and message decode for the current byte.
  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    d1_d         = d1_q;
    msg_valid_c  = 1'b0;
    msg_status_c = rs_q;
    msg_d1_c     = d1_q;
    msg_d2_c     = '0;
    if (midi_valid_i && (midi_data_i < 8'hF8)) begin
      if (midi_data_i == 8'hF0) begin
        state_d = P_SYSEX;
        rs_d    = '0;
      end else if (midi_data_i[7:4] == 4'hF) begin
        state_d = P_IDLE;
        rs_d    = '0;
      end else if (midi_data_i[7]) begin
        state_d = P_DATA1;
        rs_d    = midi_data_i;
      end else begin
        case (state_q)
          P_IDLE, P_DATA1: begin
            if (rs_q[7]) begin
              d1_d = midi_data_i[NOTE_W-1:0];
              if (is_one_data(rs_q)) begin
                msg_valid_c = 1'b1;
                msg_d1_c    = midi_data_i[NOTE_W-1:0];
                state_d     = P_DATA1;
              end else begin
                state_d = P_DATA2;
              end
            end
          end
          P_DATA2: begin
            msg_valid_c = 1'b1;
            msg_d2_c    = midi_data_i[NOTE_W-1:0];
            state_d     = P_DATA1;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Parser state, running status and first data byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= P_IDLE;
      rs_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      d1_q    <= d1_d;
    end
  end

endmodule

// File: rtl/midi_note_tracker.sv
// Monophonic voice front end: last-note-priority stack and note_repeat stretch.
module midi_note_tracker
  import midi_pkg::*;
#(
  parameter int unsigned CHANNEL     = 0,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              midi_valid,
  input  logic [BYTE_W-1:0] midi_data,
  output logic              note_on,
  output logic [NOTE_W-1:0] note_start,
  output logic [NOTE_W-1:0] vel_start,
  output logic              note_repeat
);

  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

  logic              msg_valid_c;
  logic [BYTE_W-1:0] msg_status_c;
  logic [NOTE_W-1:0] msg_d1_c;
  logic [NOTE_W-1:0] msg_d2_c;

  midi_byte_parser u_parser (
    .clk          (clk),
    .reset_n      (reset_n),
    .midi_valid_i (midi_valid),
    .midi_data_i  (midi_data),
    .msg_valid_c  (msg_valid_c),
    .msg_status_c (msg_status_c),
    .msg_d1_c     (msg_d1_c),
    .msg_d2_c     (msg_d2_c)
  );

  // Entry 0 is the newest (top) note; entries at or above cnt_q are stale.
  logic [NOTE_W-1:0] note_q [STACK_DEPTH];
  logic [NOTE_W-1:0] vel_q  [STACK_DEPTH];
  logic [NOTE_W-1:0] note_d [STACK_DEPTH];
  logic [NOTE_W-1:0] vel_d  [STACK_DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rep_q, rep_d;
  logic              note_on_q;
  logic [NOTE_W-1:0] note_start_q, vel_start_q;

  logic              chan_ok, is_on, is_off, is_clr, hit, rep_set;
  logic [IDX_W-1:0]  hit_idx;

  assign chan_ok = msg_valid_c && (msg_status_c[3:0] == 4'(CHANNEL));
  assign is_on   = chan_ok && (msg_status_c[7:4] == NOTE_ON) && (msg_d2_c != '0);
  assign is_off  = chan_ok && ((msg_status_c[7:4] == NOTE_OFF) ||
                               ((msg_status_c[7:4] == NOTE_ON) && (msg_d2_c == '0)));
  assign is_clr  = chan_ok && (msg_status_c[7:4] == CTRL) &&
                   ((msg_d1_c == CC_ALL_NOTES_OFF) || (msg_d1_c == CC_ALL_SOUND_OFF));

  // Locate the message note among the live entries.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (!hit && (CNT_W'(i) < cnt_q) && (note_q[i] == msg_d1_c)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Stack update for note-on, note-off and all-notes-off.
  always_comb begin
    note_d  = note_q;
    vel_d   = vel_q;
    cnt_d   = cnt_q;
    rep_set = 1'b0;
    if (is_on) begin
      if (hit && (hit_idx == '0)) begin
        vel_d[0] = msg_d2_c;
        rep_set  = 1'b1;
      end else begin
        // Move-to-top shifts only the entries above the old slot; a fresh push shifts all.
        for (int i = 1; i < STACK_DEPTH; i++) begin
          if (!hit || (IDX_W'(i) <= hit_idx)) begin
            note_d[i] = note_q[i-1];
            vel_d[i]  = vel_q[i-1];
          end
        end
        note_d[0] = msg_d1_c;
        vel_d[0]  = msg_d2_c;
        if (!hit && (cnt_q != CNT_W'(STACK_DEPTH))) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else if (is_off) begin
      if (hit) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) begin
          if (IDX_W'(i) >= hit_idx) begin
            note_d[i] = note_q[i+1];
            vel_d[i]  = vel_q[i+1];
          end
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (is_clr) begin
      cnt_d = '0;
    end
  end

  // Repeat request holds until the envelope has seen one enabled cycle.
  always_comb begin
    rep_d = rep_q;
    if (rep_set) begin
      rep_d = 1'b1;
    end else if (rep_q && en) begin
      rep_d = 1'b0;
    end
  end

  // Stack storage and registered voice outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
      end
      cnt_q        <= '0;
      rep_q        <= 1'b0;
      note_on_q    <= 1'b0;
      note_start_q <= '0;
      vel_start_q  <= '0;
    end else begin
      note_q       <= note_d;
      vel_q        <= vel_d;
      cnt_q        <= cnt_d;
      rep_q        <= rep_d;
      note_on_q    <= (cnt_d != '0);
      note_start_q <= (cnt_d != '0) ? note_d[0] : '0;
      vel_start_q  <= (cnt_d != '0) ? vel_d[0] : '0;
    end
  end

  assign note_on     = note_on_q;
  assign note_start  = note_start_q;
  assign vel_start   = vel_start_q;
  assign note_repeat = rep_q;

endmodule

// File: tb/tb_midi_note_tracker.sv
// Randomized bench for midi_note_tracker against a message-level queue model.
module tb_midi_note_tracker;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       midi_valid;
  logic [7:0] midi_data;
  logic       note_on;
  logic [6:0] note_start;
  logic [6:0] vel_start;
  logic       note_repeat;

  always #5 clk = ~clk;

  midi_note_tracker #(.CHANNEL(0), .STACK_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .midi_valid  (midi_valid),
    .midi_data   (midi_data),
    .note_on     (note_on),
    .note_start  (note_start),
    .vel_start   (vel_start),
    .note_repeat (note_repeat)
  );

  // Reference model: held notes newest-first, plus byte-level message assembly.
  typedef struct {
    logic [6:0] n;
    logic [6:0] v;
  } ent_t;

  ent_t       stk[$];
  int         m_rs;
  bit         m_sysex;
  logic [6:0] m_buf[$];
  bit         m_rep;
  bit         m_rep_set;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    stk.delete();
    m_buf.delete();
    m_rs    = -1;
    m_sysex = 1'b0;
    m_rep   = 1'b0;
  endtask

  task automatic model_msg(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2);
    int idx;
    idx = -1;
    if (st[3:0] != 4'd0) return;
    for (int i = 0; i < stk.size(); i++) begin
      if (idx < 0 && stk[i].n == d1) idx = i;
    end
    if (st[7:4] == 4'h9 && d2 != 7'd0) begin
      if (idx == 0) begin
        stk[0].v  = d2;
        m_rep_set = 1'b1;
      end else begin
        if (idx > 0) stk.delete(idx);
        stk.push_front('{n: d1, v: d2});
        if (stk.size() > DEPTH) void'(stk.pop_back());
      end
    end else if (st[7:4] == 4'h8 || st[7:4] == 4'h9) begin
      if (idx >= 0) stk.delete(idx);
    end else if (st[7:4] == 4'hB && (d1 == 7'd123 || d1 == 7'd120)) begin
      stk.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int need;
    if (b >= 8'hF8) return;
    if (b == 8'hF0) begin
      m_sysex = 1'b1; m_rs = -1; m_buf.delete(); return;
    end
    if (b >= 8'hF1) begin
      m_sysex = 1'b0; m_rs = -1; m_buf.delete(); return;
    end
    if (b[7]) begin
      m_sysex = 1'b0; m_rs = int'(b); m_buf.delete(); return;
    end
    if (m_sysex || m_rs < 0) return;
    m_buf.push_back(b[6:0]);
    need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
    if (m_buf.size() == need) begin
      model_msg(8'(m_rs), m_buf[0], (need == 2) ? m_buf[1] : 7'd0);
      m_buf.delete();
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_on"},   32'(note_on),     32'(stk.size() != 0));
    chk({tag, "_note"}, 32'(note_start),  (stk.size() != 0) ? 32'(stk[0].n) : 32'd0);
    chk({tag, "_vel"},  32'(vel_start),   (stk.size() != 0) ? 32'(stk[0].v) : 32'd0);
    chk({tag, "_rep"},  32'(note_repeat), 32'(m_rep));
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic tick(input bit v, input logic [7:0] b, input bit e);
    @(negedge clk);
    midi_valid = v;
    midi_data  = b;
    en         = e;
    m_rep_set  = 1'b0;
    if (v) model_byte(b);
    if (m_rep_set) m_rep = 1'b1;
    else if (m_rep && e) m_rep = 1'b0;
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    midi_valid = 1'b0;
    en         = 1'b0;
    model_clear();
    #1;
    compare_all("rst");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_byte();
    int         r;
    logic [7:0] ch;
    r  = $urandom_range(0, 99);
    ch = ($urandom_range(0, 4) == 0) ? 8'd1 : 8'd0;
    if (r < 15) return 8'h90 | ch;
    if (r < 22) return 8'h80 | ch;
    if (r < 42) return 8'($urandom_range(8'h3C, 8'h41));
    if (r < 55) return ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
    if (r < 60) return 8'($urandom_range(8'hF8, 8'hFF));
    if (r < 62) return 8'hF0;
    if (r < 65) return 8'hF7;
    if (r < 67) return 8'($urandom_range(8'hF1, 8'hF6));
    if (r < 71) return 8'hB0 | ch;
    if (r < 74) return ($urandom_range(0, 1) == 0) ? 8'd123 : 8'd120;
    if (r < 77) return ($urandom_range(0, 1) == 0) ? (8'hC0 | ch) : (8'hD0 | ch);
    if (r < 80) return ($urandom_range(0, 1) == 0) ? (8'hA0 | ch) : (8'hE0 | ch);
    return 8'($urandom_range(0, 127));
  endfunction

  initial begin
    reset_n    = 1'b0;
    en         = 1'b0;
    midi_valid = 1'b0;
    midi_data  = 8'h00;
    model_clear();
    #2;
    compare_all("init");

    // Single note-on.
    apply_reset();
    send(8'h90); send(8'h3C); send(8'h64);
    chk("tp1_on", 32'(note_on), 32'd1);
    chk("tp1_note", 32'(note_start), 32'h3C);
    chk("tp1_vel", 32'(vel_start), 32'h64);
    chk("tp1_rep", 32'(note_repeat), 32'd0);

    // Running status second note, then release falls back.
    apply_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h50);
    chk("tp2_note2", 32'(note_start), 32'h40);
    chk("tp2_vel2", 32'(vel_start), 32'h50);
    send(8'h80); send(8'h40); send(8'h00);
    chk("tp2_back_note", 32'(note_start), 32'h3C);
    chk("tp2_back_vel", 32'(vel_start), 32'h64);
    chk("tp2_back_on", 32'(note_on), 32'd1);

    // Retrigger of the top note and the repeat stretch.
    apply_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3C); send(8'h20);
    chk("tp3_vel", 32'(vel_start), 32'h20);
    chk("tp3_rep_set", 32'(note_repeat), 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, 1'b0);
    chk("tp3_rep_hold", 32'(note_repeat), 32'd1);
    tick(1'b0, 8'h00, 1'b1);
    chk("tp3_rep_en", 32'(note_repeat), 32'd0);

    // Realtime byte mid-message and a foreign-channel note.
    apply_reset();
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    send(8'h91); send(8'h48); send(8'h7F);
    chk("tp4_note", 32'(note_start), 32'h3C);
    chk("tp4_vel", 32'(vel_start), 32'h64);

    // Stack overflow drops the oldest note.
    apply_reset();
    for (int n = 8'h30; n <= 8'h34; n++) begin
      send(8'h90); send(8'(n)); send(8'h40);
    end
    chk("tp5_top", 32'(note_start), 32'h34);
    for (int n = 8'h34; n >= 8'h31; n--) begin
      send(8'h80); send(8'(n)); send(8'h00);
      if (n > 8'h31) chk("tp5_fallback", 32'(note_start), 32'(n - 1));
    end
    chk("tp5_empty_on", 32'(note_on), 32'd0);

    // All-notes-off and reset in the middle of a message.
    apply_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'hB0); send(8'h7B); send(8'h00);
    chk("tp6_on", 32'(note_on), 32'd0);
    chk("tp6_note", 32'(note_start), 32'd0);
    chk("tp6_vel", 32'(vel_start), 32'd0);
    send(8'h90); send(8'h3C);
    apply_reset();
    send(8'h64);
    chk("tp6_rst_on", 32'(note_on), 32'd0);

    // Random traffic.
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 799) == 0) apply_reset();
      else tick($urandom_range(0, 9) < 6, rand_byte(), $urandom_range(0, 9) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
